ysyx_22050078_idu_stage: RTL

Pipelined RV64I/RV32I decode stage with a registered output.
- Takes fetched instruction and PC from IFU over a valid/ready handshake.
- Reads the register file combinationally and decodes every base-ISA format: I, S, B, U, J and R.
- Holds one decoded bundle (operands, immediate, rd, control fields) in an output pipeline register for EXU.
- Supports backpressure, flush and illegal-instruction flagging.
- Successor to the single-cycle addi-only decoder.

---
 rtl/ysyx_22050078_idu_stage_pkg.sv | 116 +++++++++++
 rtl/ysyx_22050078_immgen.sv | 42 ++++
 rtl/ysyx_22050078_idu_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22050078_idu_stage_pkg.sv
// ysyx_22050078_idu_stage_pkg
// Shared definitions for the IDU decode stage: base-ISA opcode constants,
// the immediate-format and operand-source enums, and a helper that maps an
// opcode to its decode control fields.
package ysyx_22050078_idu_stage_pkg;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef enum logic [1:0] {
    SRC_REG,
    SRC_PC,
    SRC_ZERO
  } op_src_e;

  typedef struct packed {
    logic     legal;
    imm_fmt_e imm_fmt;
    op_src_e  op1_src;
    logic     op2_reg;
    logic     is_store;
    logic     writes_rd;
  } dec_ctrl_t;

  // Unknown opcodes fall through to the default, which zeroes every operand
  // path; the *-32 opcodes only exist when the datapath is 64 bits wide.
  function automatic dec_ctrl_t decode_opcode(input logic [6:0] opc, input logic rv64);
    dec_ctrl_t c;
    c.legal     = 1'b0;
    c.imm_fmt   = IMM_NONE;
    c.op1_src   = SRC_ZERO;
    c.op2_reg   = 1'b0;
    c.is_store  = 1'b0;
    c.writes_rd = 1'b0;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        c.legal     = 1'b1;
        c.imm_fmt   = IMM_I;
        c.op1_src   = SRC_REG;
        c.writes_rd = 1'b1;
      end
      OPC_OP_IMM_32: begin
        if (rv64) begin
          c.legal     = 1'b1;
          c.imm_fmt   = IMM_I;
          c.op1_src   = SRC_REG;
          c.writes_rd = 1'b1;
        end
      end
      OPC_OP: begin
        c.legal     = 1'b1;
        c.op1_src   = SRC_REG;
        c.op2_reg   = 1'b1;
        c.writes_rd = 1'b1;
      end
      OPC_OP_32: begin
        if (rv64) begin
          c.legal     = 1'b1;
          c.op1_src   = SRC_REG;
          c.op2_reg   = 1'b1;
          c.writes_rd = 1'b1;
        end
      end
      OPC_BRANCH: begin
        c.legal   = 1'b1;
        c.imm_fmt = IMM_B;
        c.op1_src = SRC_REG;
        c.op2_reg = 1'b1;
      end
      OPC_STORE: begin
        c.legal    = 1'b1;
        c.imm_fmt  = IMM_S;
        c.op1_src  = SRC_REG;
        c.is_store = 1'b1;
      end
      OPC_LUI: begin
        c.legal     = 1'b1;
        c.imm_fmt   = IMM_U;
        c.writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        c.legal     = 1'b1;
        c.imm_fmt   = IMM_U;
        c.op1_src   = SRC_PC;
        c.writes_rd = 1'b1;
      end
      OPC_JAL: begin
        c.legal     = 1'b1;
        c.imm_fmt   = IMM_J;
        c.op1_src   = SRC_PC;
        c.writes_rd = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_22050078_immgen.sv
// ysyx_22050078_immgen
// Combinational immediate generator. Assembles the raw immediate for the
// selected instruction format and sign-extends it from inst[31].
// Ports:
//   inst  in   instruction bits [31:7] (opcode bits carry no immediate)
//   fmt   in   immediate format select
//   imm   out  sign-extended immediate, DATA_WIDTH bits (0 for IMM_NONE)
module ysyx_22050078_immgen
  import ysyx_22050078_idu_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:7]           inst,
  input  imm_fmt_e              fmt,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format already carries its sign in bit 31, so widening only
  // replicates that bit.
  generate
    if (DATA_WIDTH > 32) begin : g_sext
      assign imm = {{(DATA_WIDTH-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32[DATA_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/ysyx_22050078_idu_stage.sv
// ysyx_22050078_idu_stage
// Pipelined RV64I/RV32I decode stage. Accepts an instruction from the IFU
// over valid/ready, reads the register file combinationally, decodes the
// operands and immediate, and holds one decoded bundle for the EXU.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         IFU handshake
//   inst_in, pc_in            fetched instruction and its address
//   rs1_addr, rs2_addr        combinational regfile read indices
//   src1_in, src2_in          regfile read data (same cycle)
//   flush                     drop held and incoming instruction
//   out_valid/out_ready       EXU handshake
//   inst_out .. illegal       registered decoded bundle
module ysyx_22050078_idu_stage
  import ysyx_22050078_idu_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] inst_in,
  input  logic [PC_WIDTH-1:0]   pc_in,
  output logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0] src1_in,
  input  logic [DATA_WIDTH-1:0] src2_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [6:0]            opcode,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic                  illegal
);

  localparam logic RV64 = (DATA_WIDTH == 64);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  illegal;
  } bundle_t;

  bundle_t               bundle_d, bundle_q, in_bundle;
  logic                  out_valid_d, out_valid_q;
  dec_ctrl_t             ctrl;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] pc_ext;
  logic                  accept;

  assign rs1_addr = inst_in[19:15];
  assign rs2_addr = inst_in[24:20];
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign ctrl = decode_opcode(inst_in[6:0], RV64);

  ysyx_22050078_immgen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_immgen (
    .inst(inst_in[31:7]),
    .fmt (ctrl.imm_fmt),
    .imm (imm_ext)
  );

  // The PC operand is zero-extended or truncated to the datapath width.
  generate
    if (PC_WIDTH >= DATA_WIDTH) begin : g_pc_trunc
      assign pc_ext = pc_in[DATA_WIDTH-1:0];
    end else begin : g_pc_zext
      assign pc_ext = {{(DATA_WIDTH-PC_WIDTH){1'b0}}, pc_in};
    end
  endgenerate

  always_comb begin
    in_bundle         = '0;
    in_bundle.inst    = inst_in;
    in_bundle.pc      = pc_in;
    in_bundle.opcode  = inst_in[6:0];
    in_bundle.func3   = inst_in[14:12];
    in_bundle.func7   = inst_in[31:25];
    in_bundle.rd      = ctrl.writes_rd ? inst_in[11:7] : '0;
    in_bundle.imm     = imm_ext;
    in_bundle.illegal = !ctrl.legal;
    case (ctrl.op1_src)
      SRC_REG: in_bundle.op1 = src1_in;
      SRC_PC:  in_bundle.op1 = pc_ext;
      default: in_bundle.op1 = '0;
    endcase
    // Illegal opcodes decode to IMM_NONE, so the immediate path is already 0.
    if (!ctrl.legal)       in_bundle.op2 = '0;
    else if (ctrl.op2_reg) in_bundle.op2 = src2_in;
    else                   in_bundle.op2 = imm_ext;
    in_bundle.store_data = ctrl.is_store ? src2_in : '0;
  end

  // Flush wins over accept; a plain drain with nothing incoming empties the
  // stage. The bundle itself only changes on accept, so a held or drained
  // stage keeps stable outputs.
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = in_bundle;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign inst_out   = bundle_q.inst;
  assign pc_out     = bundle_q.pc;
  assign opcode     = bundle_q.opcode;
  assign func3      = bundle_q.func3;
  assign func7      = bundle_q.func7;
  assign rd_addr    = bundle_q.rd;
  assign op1        = bundle_q.op1;
  assign op2        = bundle_q.op2;
  assign imm        = bundle_q.imm;
  assign store_data = bundle_q.store_data;
  assign illegal    = bundle_q.illegal;

endmodule
